branch_offset_encoder: RTL and testbench

Multicycle inverse of the branch-target adder. Given a branch target address and the PC, it produces the 16-bit immediate that the target adder turns back into that target. The adder computes `{imm[15], imm[13:0], 1'b0} + pc`, and this block solves that equation for `imm`. It uses a bit-serial subtractor and sits on the assembler/loader and self-modifying-branch path next to the datapath, sharing the same clock.

---
 rtl/branch_offset_encoder.sv | 131 +++++++++++++
 tb/tb_branch_offset_encoder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_offset_encoder.sv
// branch_offset_encoder
// Multicycle inverse of the branch-target adder. The adder computes
// {imm[15], imm[13:0], 1'b0} + pc; this block solves that for imm, given a
// target and a pc, using a bit-serial (LSB-first) subtractor.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   start      in   1   conversion request, sampled only while idle
//   target     in  16   branch destination, captured on accept
//   pc         in  16   base pc, captured on accept
//   busy       out  1   conversion in progress
//   done       out  1   one-cycle pulse, offset/misaligned just updated
//   offset     out 16   encoded immediate in target-adder input format
//   misaligned out  1   target-pc was odd; offset is truncated
module branch_offset_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] target,
  input  logic [15:0] pc,
  output logic        busy,
  output logic        done,
  output logic [15:0] offset,
  output logic        misaligned
);

  localparam int unsigned W  = 16;
  localparam int unsigned CW = 4;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    diff_q, diff_d;
  logic            borrow_q, borrow_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [W-1:0]    offset_q, offset_d;
  logic            mis_q, mis_d;

  // One full-subtractor slice on the current LSBs
  logic            diff_bit;
  logic            borrow_nxt;
  logic [W-1:0]    diff_shift;

  assign diff_bit   = a_q[0] ^ b_q[0] ^ borrow_q;
  assign borrow_nxt = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & borrow_q);
  assign diff_shift = {diff_bit, diff_q[W-1:1]};

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      offset_q <= '0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      offset_q <= offset_d;
      mis_q    <= mis_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    offset_d = offset_q;
    mis_d    = mis_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = target;
          b_d      = pc;
          borrow_d = 1'b0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = CALC;
        end
      end
      CALC: begin
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        diff_d   = diff_shift;
        borrow_d = borrow_nxt;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          state_d  = IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          // Bit 14 is ignored by the adder, so it carries a sign copy
          offset_d = {diff_shift[W-1], diff_shift[W-1], diff_shift[W-2:1]};
          mis_d    = diff_shift[0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign offset     = offset_q;
  assign misaligned = mis_q;

endmodule

// File: tb/tb_branch_offset_encoder.sv
// Self-checking bench for branch_offset_encoder: a cycle-level reference
// model compared on every falling edge, plus directed literal checks.
module tb_branch_offset_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] target;
  logic [15:0] pc;
  logic        busy;
  logic        done;
  logic [15:0] offset;
  logic        misaligned;

  int errors = 0;
  int checks = 0;

  branch_offset_encoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .target     (target),
    .pc         (pc),
    .busy       (busy),
    .done       (done),
    .offset     (offset),
    .misaligned (misaligned)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Encoding rule: arithmetic halving of the wrapped difference
  function automatic logic [15:0] enc(input logic [15:0] diff);
    logic signed [15:0] s;
    s = diff;
    return 16'(s >>> 1);
  endfunction

  // The branch-target adder this block inverts
  function automatic logic [15:0] tadd(input logic [15:0] imm, input logic [15:0] p);
    return {imm[15], imm[13:0], 1'b0} + p;
  endfunction

  // Reference model: accept, then result appears 16 edges later
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [15:0] m_off  = 16'h0000;
  logic        m_mis  = 1'b0;
  logic [15:0] m_t    = 16'h0000;
  logic [15:0] m_p    = 16'h0000;
  int          m_cnt  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_off  <= 16'h0000;
      m_mis  <= 1'b0;
      m_cnt  <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        m_cnt <= m_cnt + 1;
        if (m_cnt == 15) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_off  <= enc(m_t - m_p);
          m_mis  <= ((m_t - m_p) % 16'd2) != 16'd0;
        end
      end else if (start) begin
        m_busy <= 1'b1;
        m_cnt  <= 0;
        m_t    <= target;
        m_p    <= pc;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("model_busy", 32'(busy), 32'(m_busy));
    chk("model_done", 32'(done), 32'(m_done));
    chk("model_offset", 32'(offset), 32'(m_off));
    chk("model_misaligned", 32'(misaligned), 32'(m_mis));
  end

  // One conversion with literal expectations and latency check
  task automatic run(input logic [15:0] t, input logic [15:0] p,
                     input logic [15:0] eo, input logic em);
    int lat;
    target = t;
    pc     = p;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'd16);
    chk("offset_lit", 32'(offset), 32'(eo));
    chk("misaligned_lit", 32'(misaligned), 32'(em));
    if (!em) chk("round_trip", 32'(tadd(offset, p)), 32'(t));
    @(negedge clk);
  endtask

  initial begin
    int n;
    int dn;
    rst_n  = 1'b0;
    start  = 1'b0;
    target = 16'h0000;
    pc     = 16'h0000;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_offset", 32'(offset), 32'd0);
    chk("reset_misaligned", 32'(misaligned), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run(16'h0020, 16'h0010, 16'h0008, 1'b0);   // forward
    run(16'h0010, 16'h0020, 16'hFFF8, 1'b0);   // backward
    run(16'h0002, 16'hFFFE, 16'h0002, 1'b0);   // wrap
    run(16'h8000, 16'h0000, 16'hC000, 1'b0);   // extreme
    run(16'h0003, 16'h0000, 16'h0001, 1'b1);   // misaligned
    run(16'h0020, 16'h0010, 16'h0008, 1'b0);   // aligned clears misaligned

    // start while busy is ignored, operands stay latched
    target = 16'h0100;
    pc     = 16'h0040;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dn = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      target = target ^ 16'h5A5A;
      pc     = pc ^ 16'h0F0F;
      if (k == 5) start = 1'b1;
      if (k == 6) start = 1'b0;
      if (done) begin
        dn++;
        chk("busy_ignore_lat", 32'(k), 32'd16);
        chk("busy_ignore_offset", 32'(offset), 32'h0060);
      end
    end
    chk("busy_ignore_dones", 32'(dn), 32'd1);

    // start held high: back-to-back conversions 17 edges apart
    target = 16'h0200;
    pc     = 16'h0100;
    start  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 30);
    chk("held_first_lat", 32'(n), 32'd17);
    chk("held_offset", 32'(offset), 32'h0080);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 40);
    chk("held_spacing", 32'(n), 32'd17);
    start = 1'b0;
    repeat (2) @(negedge clk);

    // reset in the middle of a conversion
    target = 16'h0050;
    pc     = 16'h0010;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_offset", 32'(offset), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("midrst_no_done", 32'(dn), 32'd0);
    run(16'h0100, 16'h0040, 16'h0060, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
